// File: rtl/bch_pkg.sv
// GF(2^m) constants and helpers for the Chien search: field size per code, primitive
// polynomials, multiplication and alpha powers used to build the per-lane constant ROMs.
package bch_pkg;
    localparam int GF_W = 10;

    localparam logic [1:0] CODE_M6  = 2'd1;
    localparam logic [1:0] CODE_M8  = 2'd2;
    localparam logic [1:0] CODE_M10 = 2'd3;

    typedef enum logic [1:0] {IDLE, EVAL, DRAIN, DONE} state_t;

    function automatic logic [1:0] code_norm(input logic [1:0] code);
        return (code == 2'd0) ? CODE_M10 : code;
    endfunction

    function automatic int gf_m(input logic [1:0] code);
        case (code_norm(code))
            CODE_M6: return 6;
            CODE_M8: return 8;
            default: return 10;
        endcase
    endfunction

    function automatic logic [GF_W-1:0] gf_n(input logic [1:0] code);
        case (code_norm(code))
            CODE_M6: return 10'd63;
            CODE_M8: return 10'd255;
            default: return 10'd1023;
        endcase
    endfunction

    // Primitive polynomial without its x^m term.
    function automatic logic [GF_W-1:0] gf_poly(input logic [1:0] code);
        case (code_norm(code))
            CODE_M6: return 10'h003;
            CODE_M8: return 10'h01D;
            default: return 10'h009;
        endcase
    endfunction

    function automatic logic [GF_W-1:0] gf_mul_f(input logic [1:0] code,
                                                 input logic [GF_W-1:0] a,
                                                 input logic [GF_W-1:0] b);
        logic [GF_W-1:0] acc, sh, mask, top, poly;
        int m;
        m    = gf_m(code);
        mask = 10'h3FF >> (GF_W - m);
        top  = 10'd1 << (m - 1);
        poly = gf_poly(code);
        acc  = '0;
        sh   = a & mask;
        for (int k = 0; k < GF_W; k++) begin
            if (b[k]) acc = acc ^ sh;
            if ((sh & top) != '0) sh = ((sh << 1) & mask) ^ poly;
            else                  sh = (sh << 1) & mask;
        end
        return acc;
    endfunction

    function automatic logic [GF_W-1:0] gf_alpha_pow(input logic [1:0] code, input int e);
        logic [GF_W-1:0] r, b;
        r = 10'd1;
        b = 10'd2;
        for (int k = 0; k <= GF_W; k++) begin
            if (((e >> k) & 1) != 0) r = gf_mul_f(code, r, b);
            b = gf_mul_f(code, b, b);
        end
        return r;
    endfunction

    function automatic logic [GF_W-1:0] gf_alpha_inv(input logic [1:0] code, input int k);
        int n;
        n = int'(gf_n(code));
        return gf_alpha_pow(code, (n - (k % n)) % n);
    endfunction
endpackage

// File: rtl/bch_chien_search_if.sv
// Job input (Λ, code, degree) and error-location stream between Berlekamp stage and Chien search.
interface bch_chien_search_if #(
    parameter int T     = 4,
    parameter int M_MAX = 10
);
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               code;
    logic [(T+1)*M_MAX-1:0]   lambda;
    logic [3:0]               lambda_deg;
    logic                     err_valid;
    logic                     err_ready;
    logic [9:0]               err_loc;
    logic                     done;
    logic [3:0]               err_cnt;
    logic                     fail;

    modport master (
        output in_valid, code, lambda, lambda_deg, err_ready,
        input  in_ready, err_valid, err_loc, done, err_cnt, fail
    );

    modport slave (
        input  in_valid, code, lambda, lambda_deg, err_ready,
        output in_ready, err_valid, err_loc, done, err_cnt, fail
    );
endinterface

// File: rtl/gf_mul.sv
// Combinational GF(2^m) multiplier, field chosen by code; operands must be zero above m.
module gf_mul import bch_pkg::*; #(
    parameter int M_MAX = GF_W
) (
    input  logic [1:0]       i_code,
    input  logic [M_MAX-1:0] i_a,
    input  logic [M_MAX-1:0] i_b,
    output logic [M_MAX-1:0] o_p
);
    assign o_p = gf_mul_f(i_code, i_a, i_b);
endmodule

// File: rtl/bch_chien_search.sv
// Chien search, P roots tested per cycle; first EVAL one cycle after accept, root -> err_valid next cycle.
// Downstream stall on err_ready holds err_loc and pauses the sweep; in_ready low while busy.
module bch_chien_search import bch_pkg::*; #(
    parameter int T     = 4,
    parameter int P     = 4,
    parameter int M_MAX = GF_W
) (
    input  logic clk,
    input  logic rstn,
    bch_chien_search_if.slave bus
);
    state_t           r_state, w_state_nxt;
    logic [1:0]       r_code;
    logic [M_MAX-1:0] r_coef [T+1];
    logic [3:0]       r_deg;
    logic [10:0]      r_jb, r_jl;
    logic [P-1:0]     r_mask;
    logic [3:0]       r_cnt;
    logic             r_force_fail;
    logic             r_done;
    logic [3:0]       r_err_cnt;
    logic             r_fail;

    logic [10:0]      w_n, w_jb_adv;
    logic [M_MAX-1:0] w_lane_c   [P][T+1];
    logic [M_MAX-1:0] w_prod     [P][T+1];
    logic [M_MAX-1:0] w_eval     [P];
    logic [M_MAX-1:0] w_step_c   [T+1];
    logic [M_MAX-1:0] w_coef_adv [T+1];
    logic [P-1:0]     w_root, w_mask_rest;
    logic [3:0]       w_low_idx;
    logic             w_found;
    logic             w_bad_in;

    assign w_n      = {1'b0, gf_n(r_code)};
    assign w_jb_adv = r_jb + 11'(P);
    assign w_bad_in = (bus.lambda[M_MAX-1:0] == '0) || (bus.lambda_deg > 4'(T));

    // Lane p evaluates Λ at α^-(j_base+p): term i is r_i scaled by α^(-i·p).
    genvar gp, gi;
    for (gp = 0; gp < P; gp++) begin : g_lane
        for (gi = 0; gi <= T; gi++) begin : g_term
            localparam logic [M_MAX-1:0] C6  = gf_alpha_inv(CODE_M6,  gi * gp);
            localparam logic [M_MAX-1:0] C8  = gf_alpha_inv(CODE_M8,  gi * gp);
            localparam logic [M_MAX-1:0] C10 = gf_alpha_inv(CODE_M10, gi * gp);
            assign w_lane_c[gp][gi] = (r_code == CODE_M6) ? C6 :
                                      (r_code == CODE_M8) ? C8 : C10;
            gf_mul #(.M_MAX(M_MAX)) u_mul (
                .i_code (r_code),
                .i_a    (r_coef[gi]),
                .i_b    (w_lane_c[gp][gi]),
                .o_p    (w_prod[gp][gi])
            );
        end
    end

    assign w_step_c[0]   = '0;
    assign w_coef_adv[0] = r_coef[0];
    for (gi = 1; gi <= T; gi++) begin : g_step
        localparam logic [M_MAX-1:0] S6  = gf_alpha_inv(CODE_M6,  gi * P);
        localparam logic [M_MAX-1:0] S8  = gf_alpha_inv(CODE_M8,  gi * P);
        localparam logic [M_MAX-1:0] S10 = gf_alpha_inv(CODE_M10, gi * P);
        assign w_step_c[gi] = (r_code == CODE_M6) ? S6 :
                              (r_code == CODE_M8) ? S8 : S10;
        gf_mul #(.M_MAX(M_MAX)) u_step (
            .i_code (r_code),
            .i_a    (r_coef[gi]),
            .i_b    (w_step_c[gi]),
            .o_p    (w_coef_adv[gi])
        );
    end

    // Lanes at or past n are masked so α^-n = 1 never aliases position 0.
    always_comb begin
        for (int p = 0; p < P; p++) begin
            w_eval[p] = '0;
            for (int i = 0; i <= T; i++)
                if (4'(i) <= r_deg) w_eval[p] = w_eval[p] ^ w_prod[p][i];
            w_root[p] = (w_eval[p] == '0) && ((r_jb + 11'(p)) < w_n);
        end
    end

    always_comb begin
        w_low_idx   = '0;
        w_mask_rest = r_mask;
        w_found     = 1'b0;
        for (int p = 0; p < P; p++) begin
            if (r_mask[p] && !w_found) begin
                w_low_idx      = 4'(p);
                w_mask_rest[p] = 1'b0;
                w_found        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.in_valid)
                    w_state_nxt = (w_bad_in || bus.lambda_deg == 4'd0) ? DONE : EVAL;
            end
            EVAL: begin
                if (|w_root)              w_state_nxt = DRAIN;
                else if (w_jb_adv >= w_n) w_state_nxt = DONE;
            end
            DRAIN: begin
                if (bus.err_ready && w_mask_rest == '0)
                    w_state_nxt = ((r_cnt + 4'd1) == r_deg || r_jb >= w_n) ? DONE : EVAL;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_code       <= CODE_M10;
            for (int i = 0; i <= T; i++) r_coef[i] <= '0;
            r_deg        <= '0;
            r_jb         <= '0;
            r_jl         <= '0;
            r_mask       <= '0;
            r_cnt        <= '0;
            r_force_fail <= 1'b0;
            r_done       <= 1'b0;
            r_err_cnt    <= '0;
            r_fail       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_code <= code_norm(bus.code);
                        for (int i = 0; i <= T; i++)
                            r_coef[i] <= bus.lambda[i*M_MAX +: M_MAX];
                        r_deg        <= bus.lambda_deg;
                        r_jb         <= '0;
                        r_jl         <= '0;
                        r_mask       <= '0;
                        r_cnt        <= '0;
                        r_force_fail <= w_bad_in;
                    end
                end
                EVAL: begin
                    r_coef <= w_coef_adv;
                    r_jb   <= w_jb_adv;
                    if (|w_root) begin
                        r_mask <= w_root;
                        r_jl   <= r_jb;
                    end
                end
                DRAIN: begin
                    if (bus.err_ready) begin
                        r_mask <= w_mask_rest;
                        r_cnt  <= r_cnt + 4'd1;
                    end
                end
                DONE: begin
                    r_done    <= 1'b1;
                    r_err_cnt <= r_cnt;
                    r_fail    <= r_force_fail || (r_cnt != r_deg);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.err_valid = (r_state == DRAIN);
    assign bus.err_loc   = 10'(r_jl + {7'd0, w_low_idx});
    assign bus.done      = r_done;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.fail      = r_fail;
endmodule
